// File: rtl/seq_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// Holds the control FSM state encoding and the one-hot compare result.
// Also provides the helper that folds a 1-bit cell result plus sign swap into a result code.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit order matches the {lt, eq, gt} output triple. RES_NONE only
  // exists between reset and the first completed comparison.
  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    RES_LT   = 3'b100,
    RES_EQ   = 3'b010,
    RES_GT   = 3'b001
  } result_t;

  // When the sign bit of two's-complement operands is being examined, a set
  // bit means negative, so the cell's lt/gt sense is inverted.
  function automatic result_t cell_to_result(input logic lt_b,
                                             input logic eq_b,
                                             input logic gt_b,
                                             input logic swap);
    result_t r;
    if (eq_b) begin
      r = RES_EQ;
    end else if ((lt_b && !swap) || (gt_b && swap)) begin
      r = RES_LT;
    end else begin
      r = RES_GT;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_comparator_bitcmp.sv
// 1-bit magnitude compare cell: purely combinational, zero latency, no flow control.
// Ports: a_i, b_i single operand bits; lt_o/eq_o/gt_o one-hot relation of a_i to b_i.
// Knows nothing about signedness; any sign handling is done by the caller.
module seq_comparator_bitcmp (
  input  logic a_i,
  input  logic b_i,
  output logic lt_o,
  output logic eq_o,
  output logic gt_o
);

  assign lt_o = ~a_i &  b_i;
  assign gt_o =  a_i & ~b_i;
  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/seq_comparator.sv
// Bit-serial comparator: examines captured operands one bit per clock, MSB first.
// Latency: done pulses in the cycle after the k-th RUN edge (k = bits examined, 1..WIDTH).
// Backpressure: none; start is only sampled in IDLE and dropped while busy (no queuing).
// Ports: clk, rst_n (async active-low); start/signed_mode/a/b request inputs;
//        busy (RUN or DONE), done (single-cycle pulse), lt/eq/gt registered result.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int             IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             sgn_q,   sgn_d;
  result_t          res_q,   res_d;
  // First differing bit's verdict; only needed when all bits are scanned.
  logic             found_q, found_d;
  result_t          first_q, first_d;

  logic    bit_lt, bit_eq, bit_gt;
  logic    swap;
  logic    finish;
  result_t bit_res;

  seq_comparator_bitcmp u_bitcmp (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .lt_o (bit_lt),
    .eq_o (bit_eq),
    .gt_o (bit_gt)
  );

  assign swap    = sgn_q && (idx_q == IDX_MSB);
  assign bit_res = cell_to_result(bit_lt, bit_eq, bit_gt, swap);
  // Last RUN edge: LSB reached, or a difference seen and early exit allowed.
  assign finish  = (idx_q == '0) || (EARLY_EXIT && !bit_eq);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    found_d = found_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          idx_d   = IDX_MSB;
          found_d = 1'b0;
          first_d = RES_NONE;
        end
      end
      RUN: begin
        if (!found_q && !bit_eq) begin
          found_d = 1'b1;
          first_d = bit_res;
        end
        if (finish) begin
          // bit_res is RES_EQ when this final bit matches and nothing differed.
          res_d = found_q ? first_q : bit_res;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= RES_NONE;
      found_q <= 1'b0;
      first_q <= RES_NONE;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      found_q <= found_d;
      first_q <= first_d;
    end
  end

  assign lt = res_q[2];
  assign eq = res_q[1];
  assign gt = res_q[0];

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench: two comparators (early exit on/off) share stimulus.
// Stimulus pushes expected result, completion cycle and busy length per instance;
// a negedge monitor pops and compares on every done pulse and checks result hold otherwise.
module tb_seq_comparator;

  localparam int W = 8;

  typedef struct {
    logic [2:0] res;
    int         due;
    int         k;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sg = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   busy_w, done_w, lt_w, eq_w, gt_w;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   blen[2];
  logic [2:0] hold[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sg), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .lt(lt_w[0]), .eq(eq_w[0]), .gt(gt_w[0])
  );

  seq_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sg), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .lt(lt_w[1]), .eq(eq_w[1]), .gt(gt_w[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: arithmetic comparison of the operand values; bits examined is
  // the distance from the MSB to the highest differing bit (or all of them).
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input bit sv, input bit ee,
                                output logic [2:0] r, output int k);
    longint sa, sb;
    logic [W-1:0] diff;
    bit hit;
    sa = longint'(av);
    sb = longint'(bv);
    if (sv && av[W-1]) sa = sa - (longint'(1) << W);
    if (sv && bv[W-1]) sb = sb - (longint'(1) << W);
    if (sa < sb)       r = 3'b100;
    else if (sa == sb) r = 3'b010;
    else               r = 3'b001;
    diff = av ^ bv;
    k = W;
    hit = 1'b0;
    if (ee) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (diff[i] && !hit) begin
          k = W - i;
          hit = 1'b1;
        end
      end
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [2:0] r;
    exp_t       e;
    bit         have;
    if (!rst_n) begin
      blen[0] = 0;
      blen[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        r = {lt_w[d], eq_w[d], gt_w[d]};
        if (busy_w[d]) blen[d]++; else blen[d] = 0;
        if (done_w[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            chk($sformatf("unexpected_done[%0d]", d), done_w[d], 0);
          end else begin
            chk($sformatf("result[%0d]", d), r, e.res);
            chk($sformatf("done_cycle[%0d]", d), cyc, e.due);
            chk($sformatf("busy_len[%0d]", d), blen[d], e.k + 1);
            hold[d] = e.res;
          end
        end else begin
          chk($sformatf("hold[%0d]", d), r, hold[d]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_w != 2'b00 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_w != 2'b00) chk("idle_timeout", busy_w, 0);
  endtask

  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sv,
                        input bit push, input bit inject);
    exp_t       e;
    logic [2:0] r;
    int         k;
    wait_idle();
    a = av; b = bv; sg = sv; start = 1'b1;
    if (push) begin
      model(av, bv, sv, 1'b1, r, k);
      e.res = r; e.k = k; e.due = cyc + 1 + k;
      q0.push_back(e);
      model(av, bv, sv, 1'b0, r, k);
      e.res = r; e.k = k; e.due = cyc + 1 + k;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: captured operands must not follow them.
    a = W'($urandom); b = W'($urandom); sg = 1'($urandom);
    if (inject) begin
      @(posedge clk); #1;
      a = 8'hFF; b = 8'h00; sg = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_busy[%0d]", tag, d), busy_w[d], 0);
      chk($sformatf("%s_done[%0d]", tag, d), done_w[d], 0);
      chk($sformatf("%s_res[%0d]", tag, d), {lt_w[d], eq_w[d], gt_w[d]}, 0);
    end
  endtask

  initial begin
    hold[0] = 3'b000; hold[1] = 3'b000;
    blen[0] = 0; blen[1] = 0;
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_cmp(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
    do_cmp(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_cmp(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_cmp(8'hFE, 8'hFD, 1'b1, 1'b1, 1'b0);
    do_cmp(8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    do_cmp(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
    do_cmp(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    do_cmp(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);

    // Abort mid-RUN with an asynchronous reset, then restart.
    do_cmp(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    hold[0] = 3'b000; hold[1] = 3'b000;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_cmp(8'h33, 8'h33, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      do_cmp(ra, rb, 1'($urandom), 1'b1, 1'($urandom_range(0, 4) == 0));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_q0", q0.size(), 0);
    chk("pending_q1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
